cpu_cfg_port: RTL and testbench
===============================

// Module: cpu_cfg_port
// PURPOSE
//  CPU-side end of the N64 config/command channel. N64-side register block issues command+args and
//  watches cpu_busy. This block snapshots each command for the controller CPU, raises an IRQ, exposes
//  command/args over the CPU bus, accepts the response and releases cpu_busy on CPU completion.
// PARAMETERS
//  CMD_WIDTH     8     width of command code
//  IRQ_EN_RESET  1'b0  reset value of irq_enable
// PORTS
//  clk             in   1          system clock
//  reset           in   1          asynchronous, active-high reset
//  bus_request     in   1          CPU bus access strobe
//  bus_write       in   1          1=write, 0=read
//  bus_address     in   5          byte address; register select = bus_address[4:2]
//  bus_wdata       in   32         CPU write data (full-word writes only; byte masks not supported)
//  bus_ack         out  1          one-cycle access acknowledge
//  bus_rdata       out  32         read data, valid while bus_ack=1, else 0
//  cmd_request     in   1          one-cycle pulse: N64 wrote command register
//  command         in   CMD_WIDTH  N64-written command code
//  arg0, arg1      in   32         N64-written arguments
//  boot_write      in   1          one-cycle pulse: N64 wrote boot arg (arrives on arg0)
//  response        out  32         response word shown to N64
//  cpu_busy        out  1          command in progress
//  cpu_bootstrapped out 1          CPU has finished boot
//  irq             out  1          CPU interrupt, level
// BEHAVIOUR
//  Reset: state=S_IDLE; bus_ack, cpu_busy, cpu_bootstrapped, irq, overrun, boot_pending = 0;
//   response, latched cmd/args/boot_arg = 0; irq_enable=IRQ_EN_RESET. Async reset aborts any access at once.
//  Bus: request sampled in S_BUS_IDLE -> bus_ack=1 next cycle, rdata combinational from address
//   while ack; following cycle is a mandatory wait (request ignored); then ready again. 2-cycle throughput.
//  Register map (word idx): 0 STATUS RO {26'd0, boot_pending, irq_enable, bootstrapped, overrun, pending, busy}
//   1 CMD RO {zero-ext, cmd_latched}; read side effect: S_PENDING->S_SERVICING
//   2 ARG0 RO; 3 ARG1 RO; 4 RESPONSE RW -> drives response
//   5 CTRL WO: b0 done, b1 clear overrun, b2 set bootstrapped (sticky until reset), b3 irq_enable (written every CTRL write)
//   6 BOOT_ARG RO; read clears boot_pending; 7 reserved: reads 0, writes ignored.
//  Command FSM:
//   S_IDLE: cmd_request -> latch command/arg0/arg1, cpu_busy=1, -> S_PENDING.
//   S_PENDING: CMD read -> S_SERVICING; CTRL.done -> S_IDLE (abort).
//   S_SERVICING: CTRL.done -> S_IDLE, cpu_busy=0 next cycle.
//   cmd_request in S_PENDING/S_SERVICING: command dropped, latches untouched, overrun=1.
//   cmd_request same cycle as accepted CTRL.done: done applied, new command accepted -> S_PENDING; cpu_busy stays 1.
//  pending = (state==S_PENDING); irq = pending & irq_enable, registered (1-cycle after entry/exit).
//  boot_write: latch arg0 into boot_arg, boot_pending=1; boot_write with BOOT_ARG read same cycle: set wins.
//  Overrun set and CTRL clear-overrun same cycle: set wins.
//  RESPONSE write takes effect the cycle after the request is sampled (together with bus_ack).
// STRUCTURE
//  Package cfg_port_pkg: e_cmd_state {S_IDLE,S_PENDING,S_SERVICING}, e_bus_state {S_BUS_IDLE,S_BUS_WAIT},
//   register index constants REG_STATUS..REG_BOOT_ARG, CTRL_* and STATUS_* bit indices.
//  Single module; no sub-module warranted.
// TESTING
//  cmd_request cmd=0x12,arg0=0xDEADBEEF,arg1=0x1 with irq_en=1 -> cpu_busy=1, irq=1; CMD read returns 0x12, irq drops; ARG0=0xDEADBEEF.
//  Write RESPONSE=0xCAFE0001, CTRL=0x9 -> response=0xCAFE0001, cpu_busy=0 next cycle, state S_IDLE, irq_en kept 1.
//  Second cmd_request (cmd=0x34) while S_SERVICING -> STATUS.overrun=1, CMD still 0x12; CTRL=0xA clears overrun.
//  cmd_request same cycle CTRL.done accepted -> cpu_busy stays 1, CMD reads new code, STATUS.pending=1.
//  Back-to-back bus_request held high -> bus_ack pulses every 2nd cycle; reads of idx 7 return 0.
//  boot_write arg0=0x00000005 then BOOT_ARG read -> 0x5, boot_pending 1->0; assert reset mid-access -> all outputs 0 immediately.

Source files
------------

// File: rtl/cfg_port_pkg.sv
// Shared types and register map for the CPU-side command/config port.
// Register indices are word offsets (bus_address[4:2]).
package cfg_port_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_SERVICING
    } e_cmd_state;

    typedef enum logic {
        S_BUS_IDLE,
        S_BUS_WAIT
    } e_bus_state;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CMD      = 3'd1;
    localparam logic [2:0] REG_ARG0     = 3'd2;
    localparam logic [2:0] REG_ARG1     = 3'd3;
    localparam logic [2:0] REG_RESPONSE = 3'd4;
    localparam logic [2:0] REG_CTRL     = 3'd5;
    localparam logic [2:0] REG_BOOT_ARG = 3'd6;

    localparam int CTRL_DONE        = 0;
    localparam int CTRL_CLR_OVERRUN = 1;
    localparam int CTRL_SET_BOOT    = 2;
    localparam int CTRL_IRQ_EN      = 3;

    localparam int STATUS_BUSY         = 0;
    localparam int STATUS_PENDING      = 1;
    localparam int STATUS_OVERRUN      = 2;
    localparam int STATUS_BOOTSTRAPPED = 3;
    localparam int STATUS_IRQ_EN       = 4;
    localparam int STATUS_BOOT_PENDING = 5;

endpackage

// File: rtl/cpu_cfg_port.sv
// CPU-side end of the N64 command channel: snapshots commands, raises irq,
// exposes command/args on a 2-cycle CPU bus and releases cpu_busy on done.
//
// state        | meaning
// S_IDLE       | no command outstanding, cpu_busy low
// S_PENDING    | command latched, CPU not yet read CMD (irq source)
// S_SERVICING  | CPU has read CMD, waiting for CTRL.done
module cpu_cfg_port
    import cfg_port_pkg::*;
#(
    parameter int   CMD_WIDTH    = 8,
    parameter logic IRQ_EN_RESET = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_request,
    input  logic                 bus_write,
    input  logic [4:0]           bus_address,
    input  logic [31:0]          bus_wdata,
    output logic                 bus_ack,
    output logic [31:0]          bus_rdata,
    input  logic                 cmd_request,
    input  logic [CMD_WIDTH-1:0] command,
    input  logic [31:0]          arg0,
    input  logic [31:0]          arg1,
    input  logic                 boot_write,
    output logic [31:0]          response,
    output logic                 cpu_busy,
    output logic                 cpu_bootstrapped,
    output logic                 irq
);

    e_bus_state           bus_state;
    e_cmd_state           state;
    e_cmd_state           state_next;
    logic [2:0]           reg_idx;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [31:0]          arg0_q;
    logic [31:0]          arg1_q;
    logic [31:0]          boot_arg;
    logic                 overrun;
    logic                 boot_pending;
    logic                 irq_enable;
    logic                 pending;
    logic                 cmd_accept;
    logic                 cmd_drop;
    logic [31:0]          status;
    logic [31:0]          rdata_mux;
    logic                 unused_addr_bits;

    // Side effects of an access are applied on the sampling edge, so they
    // are already visible during the ack cycle.
    logic access, rd_acc, wr_acc;
    logic cmd_rd, boot_rd, resp_wr, ctrl_wr, done;

    assign access  = (bus_state == S_BUS_IDLE) && bus_request;
    assign rd_acc  = access && !bus_write;
    assign wr_acc  = access && bus_write;
    assign cmd_rd  = rd_acc && (bus_address[4:2] == REG_CMD);
    assign boot_rd = rd_acc && (bus_address[4:2] == REG_BOOT_ARG);
    assign resp_wr = wr_acc && (bus_address[4:2] == REG_RESPONSE);
    assign ctrl_wr = wr_acc && (bus_address[4:2] == REG_CTRL);
    assign done    = ctrl_wr && bus_wdata[CTRL_DONE];

    assign unused_addr_bits = ^bus_address[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_state <= S_BUS_IDLE;
            reg_idx   <= '0;
        end else begin
            bus_state <= access ? S_BUS_WAIT : S_BUS_IDLE;
            if (access) reg_idx <= bus_address[4:2];
        end
    end

    assign bus_ack = (bus_state == S_BUS_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_accept = 1'b0;
        cmd_drop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_request) begin
                    cmd_accept = 1'b1;
                    state_next = S_PENDING;
                end
            end
            S_PENDING, S_SERVICING: begin
                if (done) begin
                    // A command arriving with done is taken straight away.
                    state_next = cmd_request ? S_PENDING : S_IDLE;
                    cmd_accept = cmd_request;
                end else begin
                    cmd_drop = cmd_request;
                    if (state == S_PENDING && cmd_rd) state_next = S_SERVICING;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_busy = (state != S_IDLE);
        pending  = (state == S_PENDING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q            <= '0;
            arg0_q           <= '0;
            arg1_q           <= '0;
            boot_arg         <= '0;
            response         <= '0;
            overrun          <= 1'b0;
            boot_pending     <= 1'b0;
            cpu_bootstrapped <= 1'b0;
            irq_enable       <= IRQ_EN_RESET;
            irq              <= 1'b0;
        end else begin
            if (cmd_accept) begin
                cmd_q  <= command;
                arg0_q <= arg0;
                arg1_q <= arg1;
            end
            if (cmd_drop)
                overrun <= 1'b1;
            else if (ctrl_wr && bus_wdata[CTRL_CLR_OVERRUN])
                overrun <= 1'b0;
            if (ctrl_wr) begin
                irq_enable <= bus_wdata[CTRL_IRQ_EN];
                if (bus_wdata[CTRL_SET_BOOT]) cpu_bootstrapped <= 1'b1;
            end
            if (resp_wr) response <= bus_wdata;
            if (boot_write) begin
                boot_arg     <= arg0;
                boot_pending <= 1'b1;
            end else if (boot_rd) begin
                boot_pending <= 1'b0;
            end
            irq <= pending & irq_enable;
        end
    end

    always_comb begin
        status                      = '0;
        status[STATUS_BUSY]         = cpu_busy;
        status[STATUS_PENDING]      = pending;
        status[STATUS_OVERRUN]      = overrun;
        status[STATUS_BOOTSTRAPPED] = cpu_bootstrapped;
        status[STATUS_IRQ_EN]       = irq_enable;
        status[STATUS_BOOT_PENDING] = boot_pending;
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_idx)
            REG_STATUS:   rdata_mux = status;
            REG_CMD:      rdata_mux = 32'(cmd_q);
            REG_ARG0:     rdata_mux = arg0_q;
            REG_ARG1:     rdata_mux = arg1_q;
            REG_RESPONSE: rdata_mux = response;
            REG_BOOT_ARG: rdata_mux = boot_arg;
            default:      rdata_mux = '0;
        endcase
        bus_rdata = bus_ack ? rdata_mux : '0;
    end

endmodule

// File: tb/tb_cpu_cfg_port.sv
// Directed bench for cpu_cfg_port: read expectations go through a scoreboard
// queue and are popped when bus_ack returns the data.
module tb_cpu_cfg_port;

    logic        clk;
    logic        reset;
    logic        bus_request;
    logic        bus_write;
    logic [4:0]  bus_address;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        cmd_request;
    logic [7:0]  command;
    logic [31:0] arg0;
    logic [31:0] arg1;
    logic        boot_write;
    logic [31:0] response;
    logic        cpu_busy;
    logic        cpu_bootstrapped;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    cpu_cfg_port #(.CMD_WIDTH(8), .IRQ_EN_RESET(1'b0)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus_request      (bus_request),
        .bus_write        (bus_write),
        .bus_address      (bus_address),
        .bus_wdata        (bus_wdata),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata),
        .cmd_request      (cmd_request),
        .command          (command),
        .arg0             (arg0),
        .arg1             (arg1),
        .boot_write       (boot_write),
        .response         (response),
        .cpu_busy         (cpu_busy),
        .cpu_bootstrapped (cpu_bootstrapped),
        .irq              (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        logic got;
        got = 1'b0;
        exp_q.push_back(exp);
        bus_request = 1'b1;
        bus_write   = 1'b0;
        bus_address = {idx, 2'b00};
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (bus_ack) got = 1'b1;
        end
        bus_request = 1'b0;
        if (got) check(tag, bus_rdata, exp_q.pop_front());
        else begin
            void'(exp_q.pop_front());
            check({tag, "_ack"}, 32'(got), 32'd1);
        end
    endtask

    task automatic bus_wr(input logic [2:0] idx, input logic [31:0] data, input string tag);
        logic got;
        got = 1'b0;
        bus_request = 1'b1;
        bus_write   = 1'b1;
        bus_address = {idx, 2'b00};
        bus_wdata   = data;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (bus_ack) got = 1'b1;
        end
        bus_request = 1'b0;
        bus_write   = 1'b0;
        if (!got) check({tag, "_ack"}, 32'(got), 32'd1);
    endtask

    task automatic cmd_pulse(input logic [7:0] c, input logic [31:0] a0, input logic [31:0] a1);
        cmd_request = 1'b1;
        command     = c;
        arg0        = a0;
        arg1        = a1;
        tick();
        cmd_request = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        bus_request = 1'b0;
        bus_write   = 1'b0;
        bus_address = '0;
        bus_wdata   = '0;
        cmd_request = 1'b0;
        command     = '0;
        arg0        = '0;
        arg1        = '0;
        boot_write  = 1'b0;
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_resp", response, 32'd0);
        check("rst_boot", 32'(cpu_bootstrapped), 32'd0);
        reset = 1'b0;
        tick();

        bus_rd(3'd0, 32'h0, "status_reset");
        bus_wr(3'd5, 32'h8, "ctrl_irq_en");
        bus_rd(3'd0, 32'h10, "status_irq_en");

        // First command: pending raises irq one cycle after entry
        cmd_pulse(8'h12, 32'hDEADBEEF, 32'h1);
        check("busy_after_cmd", 32'(cpu_busy), 32'd1);
        tick();
        check("irq_raised", 32'(irq), 32'd1);
        bus_rd(3'd1, 32'h12, "cmd_read");
        tick();
        check("irq_dropped", 32'(irq), 32'd0);
        bus_rd(3'd0, 32'h11, "status_servicing");
        bus_rd(3'd2, 32'hDEADBEEF, "arg0_read");
        bus_rd(3'd3, 32'h1, "arg1_read");

        // Overrun while servicing: dropped command, latch untouched
        cmd_pulse(8'h34, 32'h11111111, 32'h22222222);
        bus_rd(3'd0, 32'h15, "status_overrun");
        bus_rd(3'd1, 32'h12, "cmd_kept");
        bus_rd(3'd2, 32'hDEADBEEF, "arg0_kept");
        bus_wr(3'd5, 32'hA, "ctrl_clr_ovr");
        bus_rd(3'd0, 32'h11, "status_ovr_cleared");

        bus_wr(3'd4, 32'hCAFE0001, "resp_wr");
        check("response_out", response, 32'hCAFE0001);
        bus_wr(3'd5, 32'h9, "ctrl_done");
        check("busy_released", 32'(cpu_busy), 32'd0);
        bus_rd(3'd0, 32'h10, "status_idle");
        bus_rd(3'd4, 32'hCAFE0001, "resp_read");

        // New command arriving on the same edge as an accepted done
        cmd_pulse(8'h55, 32'h0, 32'h0);
        bus_rd(3'd1, 32'h55, "cmd55_read");
        tick();
        bus_request = 1'b1;
        bus_write   = 1'b1;
        bus_address = {3'd5, 2'b00};
        bus_wdata   = 32'h9;
        cmd_request = 1'b1;
        command     = 8'h77;
        arg0        = 32'h00000077;
        arg1        = 32'h0;
        tick();
        cmd_request = 1'b0;
        bus_request = 1'b0;
        bus_write   = 1'b0;
        check("done_cmd_ack", 32'(bus_ack), 32'd1);
        check("done_cmd_busy", 32'(cpu_busy), 32'd1);
        bus_rd(3'd0, 32'h13, "status_new_pending");
        bus_rd(3'd1, 32'h77, "cmd77_read");
        bus_wr(3'd5, 32'h9, "ctrl_done2");
        check("busy_released2", 32'(cpu_busy), 32'd0);

        // Request held high: ack every second cycle, reserved reads zero
        tick();
        bus_request = 1'b1;
        bus_write   = 1'b0;
        bus_address = {3'd7, 2'b00};
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("b2b_ack_%0d", i), 32'(bus_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (bus_ack) begin
                exp_q.push_back(32'h0);
                check($sformatf("b2b_rdata_%0d", i), bus_rdata, exp_q.pop_front());
            end
        end
        bus_request = 1'b0;
        bus_wr(3'd7, 32'hFFFFFFFF, "rsvd_wr");
        bus_rd(3'd4, 32'hCAFE0001, "resp_after_rsvd");
        bus_rd(3'd0, 32'h10, "status_after_rsvd");

        // Bootstrapped is sticky across later CTRL writes
        bus_wr(3'd5, 32'hC, "ctrl_set_boot");
        check("bootstrapped_set", 32'(cpu_bootstrapped), 32'd1);
        bus_wr(3'd5, 32'h8, "ctrl_no_boot");
        check("bootstrapped_sticky", 32'(cpu_bootstrapped), 32'd1);
        bus_rd(3'd0, 32'h18, "status_boot");

        boot_write = 1'b1;
        arg0       = 32'h00000005;
        tick();
        boot_write = 1'b0;
        bus_rd(3'd0, 32'h38, "status_boot_pending");
        bus_rd(3'd6, 32'h5, "boot_arg_read");
        bus_rd(3'd0, 32'h18, "status_boot_cleared");

        // Reset in the middle of an access with outputs active
        cmd_pulse(8'h66, 32'h0BADF00D, 32'h0);
        tick();
        check("irq_before_reset", 32'(irq), 32'd1);
        tick();
        bus_request = 1'b1;
        bus_write   = 1'b0;
        bus_address = {3'd2, 2'b00};
        tick();
        check("mid_ack", 32'(bus_ack), 32'd1);
        check("mid_rdata", bus_rdata, 32'h0BADF00D);
        #2 reset = 1'b1;
        #1;
        check("arst_ack", 32'(bus_ack), 32'd0);
        check("arst_rdata", bus_rdata, 32'd0);
        check("arst_busy", 32'(cpu_busy), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_resp", response, 32'd0);
        check("arst_boot", 32'(cpu_bootstrapped), 32'd0);
        bus_request = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        bus_rd(3'd0, 32'h0, "status_after_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
